id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register, directly downstream of the ID-stage controller and register file.
//  - Captures the decoded control bundle, operands, immediate, register indices and PC each cycle.
//  - Detects load-use hazards and inserts bubbles. Honours flush and external stall requests.
//  - Keeps a saturating bubble counter for performance analysis.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/load_use_detect.sv | 39 +++
 rtl/id_ex_pipe_reg.sv | 138 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the controller output bundle used by
// the ID/EX pipeline register and its load-use detector.
package riscv_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ITYPE = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        CT_NONE   = 2'b00,
        CT_BRANCH = 2'b01,
        CT_JAL    = 2'b10,
        CT_JALR   = 2'b11
    } ctrl_transfer_e;

    // All-zero value of this bundle is a bubble: no write-back, no memory
    // access, no control transfer.
    typedef struct packed {
        logic           ALU_src;
        logic           WB_data_src;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
        alu_op_e        ALU_op;
        ctrl_transfer_e ctrl_transfer;
    } ctrl_bundle_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect.
// Inputs : EX-stage valid/mem_read/rd, ID-stage valid/opcode/rs1/rs2.
// Output : hz - the ID instruction reads a register the EX load has not
//          yet produced.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hz
);

    logic uses_rs1;
    logic uses_rs2;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OPC_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_OP_IMM: uses_rs1 = 1'b1;
            OPC_LOAD:   uses_rs1 = 1'b1;
            OPC_JALR:   uses_rs1 = 1'b1;
            default:    ;
        endcase
    end

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hz = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and
// external stall, plus a saturating count of inserted bubbles.
// Ports: clk/reset (sync, active high); id_* decoded instruction in;
// flush/ext_stall controls; stall_if_id holds PC and IF/ID; ex_* registered
// instruction out; bubble_cnt bubbles inserted since reset.
module id_ex_pipe_reg
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic            id_ALU_src,
    input  logic            id_WB_data_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [1:0]      id_ALU_op,
    input  logic [1:0]      id_ctrl_transfer,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  logic            flush,
    input  logic            ext_stall,
    output logic            stall_if_id,
    output logic            ex_valid,
    output logic            ex_ALU_src,
    output logic            ex_WB_data_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [1:0]      ex_ALU_op,
    output logic [1:0]      ex_ctrl_transfer,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_bundle_t id_ctrl;
    ctrl_bundle_t ex_ctrl;
    logic         hz;
    logic         load_bubble;

    assign id_ctrl = '{ALU_src:       id_ALU_src,
                       WB_data_src:   id_WB_data_src,
                       reg_write:     id_reg_write,
                       mem_read:      id_mem_read,
                       mem_write:     id_mem_write,
                       ALU_op:        alu_op_e'(id_ALU_op),
                       ctrl_transfer: ctrl_transfer_e'(id_ctrl_transfer)};

    load_use_detect u_lud (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .hz          (hz)
    );

    // A flushed instruction is gone, so a hazard on it must not freeze IF/ID.
    assign stall_if_id = ext_stall | (hz & ~flush);

    // Cases that put a bubble into EX: flush always, hazard only when not frozen.
    assign load_bubble = flush | (~ext_stall & hz);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_pc      <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_funct3  <= '0;
            ex_funct7  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (load_bubble) begin
                ex_valid  <= 1'b0;
                ex_ctrl   <= '0;
                ex_pc     <= '0;
                ex_rd1    <= '0;
                ex_rd2    <= '0;
                ex_imm    <= '0;
                ex_rs1    <= '0;
                ex_rs2    <= '0;
                ex_rd     <= '0;
                ex_funct3 <= '0;
                ex_funct7 <= '0;
                if (bubble_cnt != {CNT_W{1'b1}})
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
            end else if (!ext_stall) begin
                ex_valid  <= id_valid;
                ex_ctrl   <= id_valid ? id_ctrl : '0;
                ex_pc     <= id_pc;
                ex_rd1    <= id_rd1;
                ex_rd2    <= id_rd2;
                ex_imm    <= id_imm;
                ex_rs1    <= id_rs1;
                ex_rs2    <= id_rs2;
                ex_rd     <= id_rd;
                ex_funct3 <= id_funct3;
                ex_funct7 <= id_funct7;
            end
        end
    end

    assign ex_ALU_src       = ex_ctrl.ALU_src;
    assign ex_WB_data_src   = ex_ctrl.WB_data_src;
    assign ex_reg_write     = ex_ctrl.reg_write;
    assign ex_mem_read      = ex_ctrl.mem_read;
    assign ex_mem_write     = ex_ctrl.mem_write;
    assign ex_ALU_op        = ex_ctrl.ALU_op;
    assign ex_ctrl_transfer = ex_ctrl.ctrl_transfer;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a per-cycle vector table plus
// hand-written sequences for reset, hold, reset-mid-stall and saturation.
module tb_id_ex_pipe_reg;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, reset2;
    logic            id_valid;
    logic [6:0]      id_opcode;
    logic            id_ALU_src, id_WB_data_src, id_reg_write, id_mem_read, id_mem_write;
    logic [1:0]      id_ALU_op, id_ctrl_transfer;
    logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic            flush, flush2, ext_stall;

    logic            stall_if_id, ex_valid;
    logic            ex_ALU_src, ex_WB_data_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [1:0]      ex_ALU_op, ex_ctrl_transfer;
    logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [15:0]     bubble_cnt;

    // Second instance with a 2-bit counter for the saturation check.
    logic            s2_stall, s2_valid;
    logic            s2_alu_src, s2_wb, s2_rw, s2_mr, s2_mw;
    logic [1:0]      s2_alu_op, s2_ct;
    logic [XLEN-1:0] s2_pc, s2_rd1, s2_rd2, s2_imm;
    logic [4:0]      s2_rs1, s2_rs2, s2_rd;
    logic [2:0]      s2_f3;
    logic [6:0]      s2_f7;
    logic [1:0]      s2_cnt;

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_ALU_src(id_ALU_src), .id_WB_data_src(id_WB_data_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_ALU_op(id_ALU_op),
        .id_ctrl_transfer(id_ctrl_transfer), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush), .ext_stall(ext_stall),
        .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_ALU_src(ex_ALU_src),
        .ex_WB_data_src(ex_WB_data_src), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_ALU_op(ex_ALU_op), .ex_ctrl_transfer(ex_ctrl_transfer),
        .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_ALU_src(id_ALU_src), .id_WB_data_src(id_WB_data_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_ALU_op(id_ALU_op),
        .id_ctrl_transfer(id_ctrl_transfer), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush2), .ext_stall(ext_stall),
        .stall_if_id(s2_stall), .ex_valid(s2_valid), .ex_ALU_src(s2_alu_src),
        .ex_WB_data_src(s2_wb), .ex_reg_write(s2_rw), .ex_mem_read(s2_mr),
        .ex_mem_write(s2_mw), .ex_ALU_op(s2_alu_op), .ex_ctrl_transfer(s2_ct),
        .ex_pc(s2_pc), .ex_rd1(s2_rd1), .ex_rd2(s2_rd2), .ex_imm(s2_imm), .ex_rs1(s2_rs1),
        .ex_rs2(s2_rs2), .ex_rd(s2_rd), .ex_funct3(s2_f3), .ex_funct7(s2_f7),
        .bubble_cnt(s2_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                          input logic mw, input logic rw, input logic [31:0] pc);
        id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw; id_pc = pc;
        id_ALU_src = 1'b0; id_WB_data_src = 1'b0; id_ALU_op = 2'b00; id_ctrl_transfer = 2'b00;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_funct3 = '0; id_funct7 = '0;
    endtask

    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic        mr, mw, rw, fl, st;
        logic [31:0] pc;
        // expected
        logic        e_stall, e_valid;
        logic [4:0]  e_rs1, e_rd;
        logic        e_mr, e_mw, e_rw;
        logic [31:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic v, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic mr, logic mw, logic rw, logic fl,
                                logic st, logic [31:0] pc, logic e_stall, logic e_valid,
                                logic [4:0] e_rs1, logic [4:0] e_rd, logic e_mr, logic e_mw,
                                logic e_rw, logic [31:0] e_pc, logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.mr = mr; r.mw = mw;
        r.rw = rw; r.fl = fl; r.st = st; r.pc = pc; r.e_stall = e_stall; r.e_valid = e_valid;
        r.e_rs1 = e_rs1; r.e_rd = e_rd; r.e_mr = e_mr; r.e_mw = e_mw; r.e_rw = e_rw;
        r.e_pc = e_pc; r.e_cnt = e_cnt;
        return r;
    endfunction

    initial begin
        reset = 1'b1; reset2 = 1'b1; flush = 1'b0; flush2 = 1'b0; ext_stall = 1'b0;
        // Junk on the ID inputs while reset is held.
        set_id(1'b1, OPC_LOAD, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);

        // ---- reset held 2 cycles ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_ctrl", 64'({ex_ALU_src, ex_WB_data_src, ex_reg_write, ex_mem_read,
                             ex_mem_write, ex_ALU_op, ex_ctrl_transfer}), 64'd0);
        chk("rst_pc", 64'(ex_pc), 64'd0);
        chk("rst_data", 64'({ex_rd1 | ex_rd2 | ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7}), 64'd0);
        chk("rst_cnt", 64'(bubble_cnt), 64'd0);
        chk("rst_stall", 64'(stall_if_id), 64'd0);
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        // ---- table-driven per-cycle vectors ----
        //          v    op          rs1 rs2 rd  mr mw rw fl st pc        | stall valid rs1 rd  mr mw rw pc      cnt
        vt.push_back(mk(1, OPC_LOAD,   1, 0, 5, 1, 0, 1, 0, 0, 32'h100, 0, 1, 1, 5, 1, 0, 1, 32'h100, 0));
        vt.push_back(mk(1, OPC_OP,     5, 7, 6, 0, 0, 1, 0, 0, 32'h104, 1, 0, 0, 0, 0, 0, 0, 32'h0,   1));
        vt.push_back(mk(1, OPC_OP,     5, 7, 6, 0, 0, 1, 0, 0, 32'h104, 0, 1, 5, 6, 0, 0, 1, 32'h104, 1));
        vt.push_back(mk(1, OPC_LOAD,   2, 0, 0, 1, 0, 1, 0, 0, 32'h108, 0, 1, 2, 0, 1, 0, 1, 32'h108, 1));
        vt.push_back(mk(1, OPC_OP,     0, 0, 7, 0, 0, 1, 0, 0, 32'h10C, 0, 1, 0, 7, 0, 0, 1, 32'h10C, 1));
        vt.push_back(mk(1, OPC_LOAD,   3, 0, 5, 1, 0, 1, 0, 0, 32'h110, 0, 1, 3, 5, 1, 0, 1, 32'h110, 1));
        vt.push_back(mk(1, OPC_JAL,    5, 5, 1, 0, 0, 1, 0, 0, 32'h114, 0, 1, 5, 1, 0, 0, 1, 32'h114, 1));
        vt.push_back(mk(1, OPC_LOAD,   4, 0, 5, 1, 0, 1, 0, 0, 32'h118, 0, 1, 4, 5, 1, 0, 1, 32'h118, 1));
        vt.push_back(mk(1, OPC_STORE,  6, 5, 0, 0, 1, 0, 0, 0, 32'h11C, 1, 0, 0, 0, 0, 0, 0, 32'h0,   2));
        vt.push_back(mk(1, OPC_STORE,  6, 5, 0, 0, 1, 0, 0, 0, 32'h11C, 0, 1, 6, 0, 0, 1, 0, 32'h11C, 2));
        vt.push_back(mk(1, OPC_LOAD,   1, 0, 8, 1, 0, 1, 0, 0, 32'h120, 0, 1, 1, 8, 1, 0, 1, 32'h120, 2));
        // flush + hz + ext_stall together: bubble, stall from ext_stall
        vt.push_back(mk(1, OPC_OP,     8, 8, 9, 0, 0, 1, 1, 1, 32'h124, 1, 0, 0, 0, 0, 0, 0, 32'h0,   3));
        // invalid ID: data captured, control forced to 0
        vt.push_back(mk(0, OPC_OP,     8, 0, 9, 0, 1, 1, 0, 0, 32'h128, 0, 0, 8, 9, 0, 0, 0, 32'h128, 3));
        vt.push_back(mk(1, OPC_LOAD,   2, 0,10, 1, 0, 1, 0, 0, 32'h12C, 0, 1, 2,10, 1, 0, 1, 32'h12C, 3));
        // hz while ext_stall: hold, no bubble counted
        vt.push_back(mk(1, OPC_OP,    10, 3,11, 0, 0, 1, 0, 1, 32'h130, 1, 1, 2,10, 1, 0, 1, 32'h12C, 3));
        vt.push_back(mk(1, OPC_OP,    10, 3,11, 0, 0, 1, 0, 0, 32'h130, 1, 0, 0, 0, 0, 0, 0, 32'h0,   4));
        vt.push_back(mk(1, OPC_OP,    10, 3,11, 0, 0, 1, 0, 0, 32'h130, 0, 1,10,11, 0, 0, 1, 32'h130, 4));

        foreach (vt[i]) begin
            set_id(vt[i].v, vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].mr, vt[i].mw,
                   vt[i].rw, vt[i].pc);
            flush = vt[i].fl; ext_stall = vt[i].st;
            #2;
            chk($sformatf("v%0d_stall", i), 64'(stall_if_id), 64'(vt[i].e_stall));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 64'(ex_valid), 64'(vt[i].e_valid));
            chk($sformatf("v%0d_rs1", i), 64'(ex_rs1), 64'(vt[i].e_rs1));
            chk($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(vt[i].e_rd));
            chk($sformatf("v%0d_mr_mw_rw", i), 64'({ex_mem_read, ex_mem_write, ex_reg_write}),
                64'({vt[i].e_mr, vt[i].e_mw, vt[i].e_rw}));
            chk($sformatf("v%0d_pc", i), 64'(ex_pc), 64'(vt[i].e_pc));
            chk($sformatf("v%0d_cnt", i), 64'(bubble_cnt), 64'(vt[i].e_cnt));
        end
        flush = 1'b0; ext_stall = 1'b0;

        // ---- reset in the middle of a load-use stall ----
        set_id(1'b1, OPC_LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h200);
        @(posedge clk); #1;
        set_id(1'b1, OPC_OP, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0, 1'b1, 32'h204);
        #2;
        chk("rms_stall_pre", 64'(stall_if_id), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rms_valid", 64'(ex_valid), 64'd0);
        chk("rms_cnt", 64'(bubble_cnt), 64'd0);
        chk("rms_stall_post", 64'(stall_if_id), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rms_add_in_ex", 64'({ex_valid, ex_rs1, ex_rd}), 64'({1'b1, 5'd5, 5'd6}));

        // ---- STORE in EX, ext_stall for 3 cycles ----
        set_id(1'b1, OPC_STORE, 5'd9, 5'd12, 5'd0, 1'b0, 1'b1, 1'b0, 32'h300);
        id_ALU_src = 1'b1; id_WB_data_src = 1'b1; id_ALU_op = 2'b10; id_ctrl_transfer = 2'b01;
        id_rd1 = 32'h1111_2222; id_rd2 = 32'h3333_4444; id_imm = 32'hFFFF_FFF8;
        id_funct3 = 3'b010; id_funct7 = 7'h20;
        @(posedge clk); #1;
        chk("st_ctrl", 64'({ex_ALU_src, ex_WB_data_src, ex_ALU_op, ex_ctrl_transfer}),
            64'({1'b1, 1'b1, 2'b10, 2'b01}));
        chk("st_data", 64'({ex_rd1, ex_rd2}), 64'h1111_2222_3333_4444);
        chk("st_imm_f", 64'({ex_imm, ex_funct3, ex_funct7, ex_rs2}),
            64'({32'hFFFF_FFF8, 3'b010, 7'h20, 5'd12}));
        ext_stall = 1'b1;
        set_id(1'b1, OPC_OP, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 32'h304);
        id_rd1 = 32'hAAAA_AAAA; id_imm = 32'h5;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("hold%0d_stall", c), 64'(stall_if_id), 64'd1);
            @(posedge clk); #1;
            chk($sformatf("hold%0d_mw", c), 64'({ex_valid, ex_mem_write, ex_reg_write}),
                64'({1'b1, 1'b1, 1'b0}));
            chk($sformatf("hold%0d_pc_rd1", c), 64'({ex_pc, ex_rd1}), 64'h0000_0300_1111_2222);
            chk($sformatf("hold%0d_imm_rs", c), 64'({ex_imm, ex_rs1, ex_rd}),
                64'({32'hFFFF_FFF8, 5'd9, 5'd0}));
            chk($sformatf("hold%0d_cnt", c), 64'(bubble_cnt), 64'd0);
        end
        ext_stall = 1'b0;
        @(posedge clk); #1;
        chk("unhold_pc", 64'({ex_pc, ex_mem_write}), 64'({32'h304, 1'b0}));

        // ---- 2-bit counter saturation: 5 consecutive flushes ----
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        chk("sat_rst", 64'(s2_cnt), 64'd0);
        reset2 = 1'b0; flush2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] exp_cnt;
            exp_cnt = (k < 3) ? 2'(k + 1) : 2'd3;
            @(posedge clk); #1;
            chk($sformatf("sat%0d_cnt", k), 64'(s2_cnt), 64'(exp_cnt));
        end
        chk("sat_valid", 64'(s2_valid), 64'd0);
        flush2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
